// File: rtl/mem_seq_pkg.sv
// Shared FSM state encoding and default geometry for the mem_seq controller.
package mem_seq_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int ADDR_BITS_DEF  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4,
    CLEAR = 3'd5
  } state_e;

endpackage

// File: rtl/reg_mem.sv
// Single-port register memory: write on edges with wen=1, read data registered (1 cycle).
// Contents are deliberately not reset so committed writes survive a controller reset.
module reg_mem
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (wen) mem_q[addr] <= din;
    dout_q <= mem_q[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/mem_seq.sv
// Request sequencer for reg_mem: 1-cycle writes, reads respond 3 cycles after accept,
// RESP holds until rsp_ready; clr_start zeroes all words (one word per cycle).
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_BITS-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  wr_ack,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  clr_start,
  output logic                  clr_done,
  output logic                  busy,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      write_q    <= write_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    write_d    = write_q;
    rsp_data_d = rsp_data_q;
    req_ready  = 1'b0;
    wr_ack     = 1'b0;
    rsp_valid  = 1'b0;
    clr_done   = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;

    unique case (state_q)
      IDLE: begin
        // Reset already forces state IDLE, so ready must also be masked by rst.
        req_ready = !clr_start && !rst;
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (req_valid && req_ready) begin
          addr_d  = req_addr;
          data_d  = req_data;
          write_d = req_write;
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        mem_wen  = 1'b1;
        mem_addr = addr_q;
        mem_din  = data_q;
        wr_ack   = 1'b1;
        state_d  = IDLE;
      end
      READ: begin
        mem_addr = addr_q;
        state_d  = CAPT;
      end
      CAPT: begin
        rsp_data_d = mem_dout;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      CLEAR: begin
        mem_wen  = 1'b1;
        mem_addr = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          clr_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench: mem_seq driving reg_mem, table vectors, corner sequences, random ops vs array model.
module tb_mem_seq;
  import mem_seq_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int AW = ADDR_BITS_DEF;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          wr_ack, rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          clr_start, clr_done, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_wen;

  mem_seq #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .wr_ack(wr_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout)
  );

  reg_mem #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) u_mem (
    .clk(clk), .wen(mem_wen), .addr(mem_addr), .din(mem_din), .dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned ref_mem [8];

  typedef struct {
    bit wr;
    int addr;
    int data;   // write data, or expected read data
    int stall;  // RESP cycles with rsp_ready held low
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the cycle in which req_ready is seen high.
  task automatic wait_ready();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready) return;
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ready_timeout: req_ready never rose, want 1");
  endtask

  task automatic do_write(input int a, input int d);
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = AW'(a); req_data = DW'(d);
    wait_ready();
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    chk("wr_ack", 32'(wr_ack), 1);
    chk("wr_wen", 32'(mem_wen), 1);
    chk("wr_addr", 32'(mem_addr), 32'(a));
    chk("wr_din", 32'(mem_din), 32'(d));
    tick();
    #1;
    chk("wr_ack_single", 32'(wr_ack), 0);
    ref_mem[a] = 32'(d);
  endtask

  task automatic do_read(input int a, input int exp, input int stall);
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(a);
    wait_ready();
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("rd_c1_valid", 32'(rsp_valid), 0);
    chk("rd_c1_addr", 32'(mem_addr), 32'(a));
    chk("rd_c1_wen", 32'(mem_wen), 0);
    tick();
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("rd_c2_valid", 32'(rsp_valid), 0);
    tick();
    rsp_ready = (stall == 0);
    @(negedge clk);
    chk("rd_c3_valid", 32'(rsp_valid), 1);
    chk("rd_c3_data", 32'(rsp_data), 32'(exp));
    for (int s = 0; s < stall; s++) begin
      tick();
      if (s == stall - 1) rsp_ready = 1'b1;
      @(negedge clk);
      chk("rd_stall_valid", 32'(rsp_valid), 1);
      chk("rd_stall_data", 32'(rsp_data), 32'(exp));
      chk("rd_stall_ready", 32'(req_ready), 0);
    end
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("rd_done_valid", 32'(rsp_valid), 0);
    chk("rd_done_ready", 32'(req_ready), 1);
    chk("rd_hold_data", 32'(rsp_data), 32'(exp));
  endtask

  task automatic do_clear();
    clr_start = 1'b1;
    @(negedge clk);
    chk("clr_req_ready", 32'(req_ready), 0);
    tick();
    // clr_start stays high into CLEAR to show it does not restart the sweep.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) clr_start = 1'b0;
      @(negedge clk);
      chk("clr_wen", 32'(mem_wen), 1);
      chk("clr_addr", 32'(mem_addr), 32'(i));
      chk("clr_din", 32'(mem_din), 0);
      chk("clr_done", 32'(clr_done), 32'(i == 7));
      tick();
    end
    #1;
    chk("clr_after_wen", 32'(mem_wen), 0);
    chk("clr_after_busy", 32'(busy), 0);
    for (int i = 0; i < 8; i++) ref_mem[i] = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_wr_ack"}, 32'(wr_ack), 0);
    chk({tag, "_clr_done"}, 32'(clr_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_mem_wen"}, 32'(mem_wen), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_din"}, 32'(mem_din), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{wr: 1'b1, addr: 5, data: 'hA, stall: 0};
    tbl[1] = '{wr: 1'b0, addr: 5, data: 'hA, stall: 0};
    tbl[2] = '{wr: 1'b1, addr: 7, data: 'hF, stall: 0};
    tbl[3] = '{wr: 1'b0, addr: 7, data: 'hF, stall: 0};
    tbl[4] = '{wr: 1'b1, addr: 0, data: 'h3, stall: 0};
    tbl[5] = '{wr: 1'b0, addr: 0, data: 'h3, stall: 4};
    tbl[6] = '{wr: 1'b0, addr: 5, data: 'hA, stall: 1};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0; clr_start = 1'b0;
    #2;
    chk_reset_outputs("por");
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("por_rel_ready", 32'(req_ready), 1);

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].wr) do_write(tbl[v].addr, tbl[v].data);
      else           do_read(tbl[v].addr, tbl[v].data, tbl[v].stall);
    end

    // Fill, clear, then every word must read back as zero.
    for (int i = 0; i < 8; i++) do_write(i, i + 1);
    do_clear();
    for (int i = 0; i < 8; i++) do_read(i, 0, 0);

    // Simultaneous clr_start and req_valid: clear wins, the write waits.
    clr_start = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd3; req_data = 4'h6;
    @(negedge clk);
    chk("coll_ready", 32'(req_ready), 0);
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("coll_ready_clr", 32'(req_ready), 0);
      chk("coll_addr_clr", 32'(mem_addr), 32'(i));
      chk("coll_din_clr", 32'(mem_din), 0);
      tick();
    end
    @(negedge clk);
    chk("coll_ready_idle", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    chk("coll_wr_ack", 32'(wr_ack), 1);
    chk("coll_wr_addr", 32'(mem_addr), 3);
    chk("coll_wr_din", 32'(mem_din), 6);
    tick();
    for (int i = 0; i < 8; i++) ref_mem[i] = 0;
    ref_mem[3] = 6;
    do_read(3, 6, 0);

    // Reset in the 4th CLEAR cycle: words 0..2 cleared, 3..7 untouched.
    for (int i = 0; i < 8; i++) do_write(i, i + 1);
    do_read(7, 8, 0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_clr");
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("mid_clr_rel_ready", 32'(req_ready), 1);
    for (int i = 0; i < 3; i++) ref_mem[i] = 0;
    for (int i = 0; i < 8; i++) do_read(i, int'(ref_mem[i]), 0);

    // Random traffic against the array model.
    for (int n = 0; n < 80; n++) begin
      int r;
      int a;
      r = int'($urandom_range(0, 19));
      a = int'($urandom_range(0, 7));
      if (r == 0)     do_clear();
      else if (r < 9) do_write(a, int'($urandom_range(0, 15)));
      else            do_read(a, int'(ref_mem[a]), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 4: memory word width in bits.
REQ-002 Parameter ADDR_BITS, default 3: address width in bits; depth is 2**ADDR_BITS (8).
REQ-003 clk  in  1: single clock; all state changes on rising edge.
REQ-004 rst  in  1: reset, asynchronous, active-high.
REQ-005 req_valid  in  1: host request present.
REQ-006 req_ready  out  1: controller accepts a request this cycle.
REQ-007 req_write  in  1: 1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_BITS: request address.
REQ-009 req_data  in  DATA_WIDTH: write data.
REQ-010 wr_ack  out  1: one-cycle pulse; the write is being committed this cycle.
REQ-011 rsp_valid  out  1: read data available.
REQ-012 rsp_ready  in  1: host accepts read data.
REQ-013 rsp_data  out  DATA_WIDTH: read data, registered.
REQ-014 clr_start  in  1: request to zero the whole memory.
REQ-015 clr_done  out  1: one-cycle pulse when the clear completes.
REQ-016 busy  out  1: high in every state except IDLE.
REQ-017 mem_addr  out  ADDR_BITS: address to reg_mem.
REQ-018 mem_din  out  DATA_WIDTH: write data to reg_mem.
REQ-019 mem_wen  out  1: write enable to reg_mem.
REQ-020 mem_dout  in  DATA_WIDTH: registered read data from reg_mem.

Function
REQ-021 Memory contract: a write occurs on the edge where mem_wen=1; a read presents its address with mem_wen=0, and mem_dout is valid in the following cycle.
REQ-022 FSM states are IDLE, WRITE, READ, CAPT, RESP and CLEAR.
REQ-023 req_ready = (state==IDLE) && !clr_start; a request is accepted on an edge where req_valid && req_ready.
REQ-024 On acceptance, addr, data and write are latched; the next state is WRITE if write=1, otherwise READ.
REQ-025 IDLE with clr_start=1 goes to CLEAR; clr_start takes priority over a simultaneous req_valid, which is not accepted.
REQ-026 WRITE lasts one cycle: mem_wen=1, mem_addr and mem_din take the latched values, wr_ack=1; next state is IDLE.
REQ-027 READ lasts one cycle: mem_wen=0, mem_addr takes the latched address; next state is CAPT.
REQ-028 CAPT lasts one cycle: rsp_data <= mem_dout on the exiting edge; next state is RESP.
REQ-029 RESP: rsp_valid=1, with rsp_data stable until the edge where rsp_ready=1; that edge moves the state to IDLE. Read latency from the accept edge to the first rsp_valid cycle is 3 cycles.
REQ-030 CLEAR: an ADDR_BITS-bit counter starts at 0; each cycle mem_wen=1, mem_addr=counter and mem_din=0, and the counter increments.
REQ-031 CLEAR terminates in the cycle where counter==2**ADDR_BITS-1: clr_done=1 that cycle, the counter wraps to 0, and the next state is IDLE (8 cycles total).
REQ-032 clr_start, req_valid and rsp_ready are ignored outside their own states; a clr_start during CLEAR does not restart the sequence.
REQ-033 Outside WRITE and CLEAR, mem_wen=0 and mem_din=0; in IDLE, mem_addr=0.
REQ-034 rsp_data retains its last captured value after RESP; it is updated only in CAPT.

Reset
REQ-035 rst=1 forces the following immediately, regardless of clk: state IDLE, counter 0, rsp_data 0, and all latched request registers 0.
REQ-036 While rst=1: req_ready=0, rsp_valid=0, wr_ack=0, clr_done=0, busy=0, mem_wen=0, mem_addr=0 and mem_din=0.
REQ-037 A reset during any operation aborts it with no response and no ack; memory writes already committed are not undone.

Structure
REQ-038 The state encoding and the DATA_WIDTH/ADDR_BITS defaults live in the shared package mem_seq_pkg.
REQ-039 There are no sub-modules; the counter and FSM are inline; the bench instantiates mem_seq connected to reg_mem.

Verification
REQ-040 Reset, then write addr 5 data 0xA: wr_ack is high exactly 1 cycle after accept; a read of addr 5 gives rsp_data=0xA with rsp_valid high 3 cycles after accept.
REQ-041 Read with rsp_ready held 0 for 4 cycles: rsp_valid and rsp_data stay stable; req_ready stays 0 until one cycle after the rsp_ready edge.
REQ-042 Fill addresses 0..7 with 1..8, pulse clr_start: mem_wen high for exactly 8 cycles with mem_addr 0..7, and clr_done is high in the 8th; reads of all 8 addresses then return 0.
REQ-043 clr_start and req_valid asserted in the same IDLE cycle: CLEAR runs, the request is not accepted, and it is accepted in the first IDLE cycle after clr_done.
REQ-044 rst asserted in the 4th CLEAR cycle: outputs reach their reset values without a clock edge; addresses 0..2 (or 0..3, depending on edge alignment) read 0, and the rest keep their prior data.
REQ-045 Back-to-back write then read of addr 7 (data 0xF): the read returns 0xF, with no lost or duplicated wr_ack.
